// File: rtl/axilite_reg_slice.sv
// axilite_reg_slice: AXI4-Lite register slice. Every channel (AW, W, B, AR, R)
// passes through its own two-entry skid buffer. Handshake outputs come straight
// from flops, so no combinational path runs from any input port to any output
// port, and one beat per cycle is still sustained.
// DATA_WIDTH is expected to be 32 or 64; the strobe width follows as DATA_WIDTH/8.
module axilite_reg_slice #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      aclk,
  input  logic                      areset,
  // upstream (master-facing) port
  input  logic [ADDR_WIDTH-1:0]     s_awaddr,
  input  logic                      s_awvalid,
  output logic                      s_awready,
  input  logic [DATA_WIDTH-1:0]     s_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_wstrb,
  input  logic                      s_wvalid,
  output logic                      s_wready,
  output logic [1:0]                s_bresp,
  output logic                      s_bvalid,
  input  logic                      s_bready,
  input  logic [ADDR_WIDTH-1:0]     s_araddr,
  input  logic                      s_arvalid,
  output logic                      s_arready,
  output logic [DATA_WIDTH-1:0]     s_rdata,
  output logic [1:0]                s_rresp,
  output logic                      s_rvalid,
  input  logic                      s_rready,
  // downstream (slave-facing) port
  output logic [ADDR_WIDTH-1:0]     m_awaddr,
  output logic                      m_awvalid,
  input  logic                      m_awready,
  output logic [DATA_WIDTH-1:0]     m_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_wstrb,
  output logic                      m_wvalid,
  input  logic                      m_wready,
  input  logic [1:0]                m_bresp,
  input  logic                      m_bvalid,
  output logic                      m_bready,
  output logic [ADDR_WIDTH-1:0]     m_araddr,
  output logic                      m_arvalid,
  input  logic                      m_arready,
  input  logic [DATA_WIDTH-1:0]     m_rdata,
  input  logic [1:0]                m_rresp,
  input  logic                      m_rvalid,
  output logic                      m_rready
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // AW: address travels master -> slave
  axilite_skid #(.W(ADDR_WIDTH)) u_aw (
    .clk_i(aclk), .rst_i(areset),
    .in_valid_i(s_awvalid), .in_ready_o(s_awready), .in_data_i(s_awaddr),
    .out_valid_o(m_awvalid), .out_ready_i(m_awready), .out_data_o(m_awaddr)
  );

  // W: data and strobes travel master -> slave, independent of AW
  axilite_skid #(.W(DATA_WIDTH + STRB_WIDTH)) u_w (
    .clk_i(aclk), .rst_i(areset),
    .in_valid_i(s_wvalid), .in_ready_o(s_wready), .in_data_i({s_wstrb, s_wdata}),
    .out_valid_o(m_wvalid), .out_ready_i(m_wready), .out_data_o({m_wstrb, m_wdata})
  );

  // B: write response travels slave -> master, response code passed untouched
  axilite_skid #(.W(2)) u_b (
    .clk_i(aclk), .rst_i(areset),
    .in_valid_i(m_bvalid), .in_ready_o(m_bready), .in_data_i(m_bresp),
    .out_valid_o(s_bvalid), .out_ready_i(s_bready), .out_data_o(s_bresp)
  );

  // AR: read address travels master -> slave
  axilite_skid #(.W(ADDR_WIDTH)) u_ar (
    .clk_i(aclk), .rst_i(areset),
    .in_valid_i(s_arvalid), .in_ready_o(s_arready), .in_data_i(s_araddr),
    .out_valid_o(m_arvalid), .out_ready_i(m_arready), .out_data_o(m_araddr)
  );

  // R: read data and response travel slave -> master
  axilite_skid #(.W(DATA_WIDTH + 2)) u_r (
    .clk_i(aclk), .rst_i(areset),
    .in_valid_i(m_rvalid), .in_ready_o(m_rready), .in_data_i({m_rresp, m_rdata}),
    .out_valid_o(s_rvalid), .out_ready_i(s_rready), .out_data_o({s_rresp, s_rdata})
  );
endmodule

// axilite_skid: two-entry skid buffer. The main register feeds the output; the
// skid register catches the one beat that can arrive while the output stalls.
// in_ready is a flop held low through reset so the upstream sees ready only
// from the first clock edge after reset release.
module axilite_skid #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         in_rdy_q, in_rdy_d;
  logic         out_vld_q, out_vld_d;
  logic         in_fire, out_fire;

  assign in_fire     = in_valid_i & in_rdy_q;
  assign out_fire    = out_vld_q & out_ready_i;
  assign in_ready_o  = in_rdy_q;
  assign out_valid_o = out_vld_q;
  assign out_data_o  = main_q;

  // State, payload and handshake flops; reset empties the buffer and drops beats
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_rdy_q  <= 1'b0;
      out_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      main_q    <= main_d;
      skid_q    <= skid_d;
      in_rdy_q  <= in_rdy_d;
      out_vld_q <= out_vld_d;
    end
  end

  // Next-state and payload steering; handshake flops follow the next state
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      S_EMPTY: begin
        if (in_fire) begin
          state_d = S_ONE;
          main_d  = in_data_i;
        end
      end
      S_ONE: begin
        if (in_fire && !out_fire) begin
          state_d = S_FULL;
          skid_d  = in_data_i;
        end else if (in_fire && out_fire) begin
          main_d  = in_data_i;
        end else if (out_fire) begin
          state_d = S_EMPTY;
        end
      end
      S_FULL: begin
        if (out_fire) begin
          state_d = S_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = S_EMPTY;
    endcase
    in_rdy_d  = (state_d != S_FULL);
    out_vld_d = (state_d != S_EMPTY);
  end
endmodule

// File: tb/tb_axilite_reg_slice.sv
// Bench for axilite_reg_slice: each channel is modelled as a two-deep queue.
// Beats enter when the input handshake completes and leave when the output
// handshake completes; valid means "queue non-empty", ready means "fewer than
// two beats held" (and ready stays low until the first edge after reset).
module tb_axilite_reg_slice;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int N  = 1000;

  logic aclk = 1'b0;
  logic areset = 1'b0;
  logic [AW-1:0] s_awaddr = '0, s_araddr = '0;
  logic s_awvalid = 0, s_wvalid = 0, s_bready = 0, s_arvalid = 0, s_rready = 0;
  logic [DW-1:0] s_wdata = '0, m_rdata = '0;
  logic [SW-1:0] s_wstrb = '0;
  logic m_awready = 0, m_wready = 0, m_bvalid = 0, m_arready = 0, m_rvalid = 0;
  logic [1:0] m_bresp = '0, m_rresp = '0;
  logic s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0] s_bresp, s_rresp;
  logic [DW-1:0] s_rdata, m_wdata;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic [SW-1:0] m_wstrb;
  logic m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;

  always #5 aclk = ~aclk;

  axilite_reg_slice #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .aclk(aclk), .areset(areset),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  // channel views: 0=AW 1=W 2=B 3=AR 4=R (input side / output side)
  logic [4:0] iv, ir, ov, orr;
  logic [71:0] ip [5];
  logic [71:0] op [5];
  assign iv  = {m_rvalid, s_arvalid, m_bvalid, s_wvalid, s_awvalid};
  assign ir  = {m_rready, s_arready, m_bready, s_wready, s_awready};
  assign ov  = {s_rvalid, m_arvalid, s_bvalid, m_wvalid, m_awvalid};
  assign orr = {s_rready, m_arready, s_bready, m_wready, m_awready};
  always_comb begin
    ip[0] = 72'(s_awaddr);            op[0] = 72'(m_awaddr);
    ip[1] = 72'({s_wstrb, s_wdata});  op[1] = 72'({m_wstrb, m_wdata});
    ip[2] = 72'(m_bresp);             op[2] = 72'(s_bresp);
    ip[3] = 72'(s_araddr);            op[3] = 72'(m_araddr);
    ip[4] = 72'({m_rresp, m_rdata});  op[4] = 72'({s_rresp, s_rdata});
  end

  string cn [5] = '{"aw", "w", "b", "ar", "r"};
  int total = 0;
  int bad = 0;

  // behavioural model state
  logic [71:0] q [5][$];
  bit blocked = 1'b1;
  bit [4:0] last_fi;
  int rcv [5];
  int sent [5];

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 5; c++) q[c].delete();
    blocked = 1'b1;
  endtask

  // One clock cycle: compare at the falling edge, advance the model at the rising edge.
  task automatic step();
    bit [4:0] fi, fo;
    logic [71:0] ips [5];
    @(negedge aclk);
    if (areset) model_clear();
    for (int c = 0; c < 5; c++) begin
      chk({cn[c], "_valid"}, 72'(ov[c]), 72'(q[c].size() > 0));
      chk({cn[c], "_ready"}, 72'(ir[c]), 72'(!blocked && q[c].size() < 2));
      if (q[c].size() > 0) chk({cn[c], "_payload"}, op[c], q[c][0]);
      fi[c] = iv[c] & ir[c];
      fo[c] = ov[c] & orr[c];
      ips[c] = ip[c];
    end
    @(posedge aclk);
    if (areset) begin
      model_clear();
      fi = '0;
    end else begin
      blocked = 1'b0;
      for (int c = 0; c < 5; c++) begin
        if (fo[c] && q[c].size() > 0) begin
          void'(q[c].pop_front());
          rcv[c]++;
        end
        if (fi[c]) q[c].push_back(ips[c]);
      end
    end
    last_fi = fi;
    #1;
  endtask

  bit [4:0] cur_v;
  logic [71:0] cur_p [5];
  bit [4:0] rdy;

  task automatic apply();
    s_awvalid = cur_v[0]; s_awaddr = cur_p[0][AW-1:0];
    s_wvalid  = cur_v[1]; {s_wstrb, s_wdata} = cur_p[1][DW+SW-1:0];
    m_bvalid  = cur_v[2]; m_bresp = cur_p[2][1:0];
    s_arvalid = cur_v[3]; s_araddr = cur_p[3][AW-1:0];
    m_rvalid  = cur_v[4]; {m_rresp, m_rdata} = cur_p[4][DW+1:0];
    m_awready = rdy[0]; m_wready = rdy[1]; s_bready = rdy[2];
    m_arready = rdy[3]; s_rready = rdy[4];
  endtask

  initial begin
    bit done;
    int cyc;
    // reset from power-up
    #1 areset = 1'b1;
    #1;
    chk("rst_s_awready", 72'(s_awready), 72'(0));
    chk("rst_m_awvalid", 72'(m_awvalid), 72'(0));
    chk("rst_s_rvalid", 72'(s_rvalid), 72'(0));
    repeat (2) step();
    areset = 1'b0;
    step();
    chk("post_rst_s_awready", 72'(s_awready), 72'(1));
    chk("post_rst_m_bready", 72'(m_bready), 72'(1));
    chk("post_rst_s_arready", 72'(s_arready), 72'(1));

    // single write
    s_awaddr = 10'h3FC; s_awvalid = 1; s_wdata = 32'hDEADBEEF; s_wstrb = 4'hF; s_wvalid = 1;
    m_awready = 1; m_wready = 1; s_bready = 1;
    step();
    s_awvalid = 0; s_wvalid = 0;
    chk("wr_m_awaddr", 72'(m_awaddr), 72'h3FC);
    chk("wr_m_awvalid", 72'(m_awvalid), 72'(1));
    chk("wr_m_wdata", 72'(m_wdata), 72'hDEADBEEF);
    chk("wr_m_wstrb", 72'(m_wstrb), 72'hF);
    step();
    m_bresp = 2'd0; m_bvalid = 1;
    step();
    m_bvalid = 0;
    chk("wr_s_bvalid", 72'(s_bvalid), 72'(1));
    chk("wr_s_bresp", 72'(s_bresp), 72'(0));
    step();

    // single read
    s_araddr = 10'h010; s_arvalid = 1; m_arready = 1; s_rready = 1;
    step();
    s_arvalid = 0;
    chk("rd_m_araddr", 72'(m_araddr), 72'h010);
    step();
    m_rdata = 32'h12345678; m_rresp = 2'd2; m_rvalid = 1;
    step();
    m_rvalid = 0;
    chk("rd_s_rdata", 72'(s_rdata), 72'h12345678);
    chk("rd_s_rresp", 72'(s_rresp), 72'd2);
    chk("rd_s_rvalid", 72'(s_rvalid), 72'(1));
    step();

    // backpressure on AW
    m_awready = 0;
    s_awvalid = 1; s_awaddr = 10'h000; step();
    s_awaddr = 10'h004; step();
    chk("bp_full_s_awready", 72'(s_awready), 72'(0));
    s_awaddr = 10'h008; step();
    chk("bp_still_full", 72'(s_awready), 72'(0));
    chk("bp_head0", 72'(m_awaddr), 72'h000);
    m_awready = 1; step();
    chk("bp_head4", 72'(m_awaddr), 72'h004);
    step();
    s_awvalid = 0;
    chk("bp_head8", 72'(m_awaddr), 72'h008);
    step();
    chk("bp_drained", 72'(m_awvalid), 72'(0));

    // reset with two AW beats buffered
    m_awready = 0; s_awvalid = 1; s_awaddr = 10'h100; step();
    s_awaddr = 10'h104; step();
    s_awvalid = 0;
    chk("pre_rst_full", 72'(s_awready), 72'(0));
    #2 areset = 1'b1;
    #1;
    chk("mid_rst_m_awvalid", 72'(m_awvalid), 72'(0));
    chk("mid_rst_s_awready", 72'(s_awready), 72'(0));
    chk("mid_rst_s_wready", 72'(s_wready), 72'(0));
    chk("mid_rst_m_rready", 72'(m_rready), 72'(0));
    step(); step();
    areset = 1'b0;
    step();
    chk("rel_s_awready", 72'(s_awready), 72'(1));
    chk("rel_no_stale_valid", 72'(m_awvalid), 72'(0));
    chk("rel_no_stale_addr", 72'(m_awaddr), 72'(0));
    m_awready = 1;

    // streaming reads
    s_arvalid = 1; m_arready = 1; s_rready = 1;
    for (int i = 0; i < 16; i++) begin
      s_araddr = AW'(i * 4);
      step();
      chk("stream_m_araddr", 72'(m_araddr), 72'(i * 4));
      chk("stream_m_arvalid", 72'(m_arvalid), 72'(1));
      chk("stream_s_arready", 72'(s_arready), 72'(1));
    end
    s_arvalid = 0;
    step();

    // randomized traffic on all channels, W leading AW by 3 beats
    for (int c = 0; c < 5; c++) begin
      rcv[c] = 0; sent[c] = 0; cur_v[c] = 0; cur_p[c] = '0; rdy[c] = 0;
    end
    last_fi = '0;
    apply();
    cyc = 0;
    done = 0;
    while (!done && cyc < 20000) begin
      for (int c = 0; c < 5; c++) begin
        bit allow;
        if (cur_v[c] && last_fi[c]) begin
          sent[c]++;
          cur_v[c] = 0;
        end
        if (!cur_v[c]) begin
          allow = (sent[c] < N) && (c != 0 || sent[0] + 3 <= sent[1] || sent[1] == N);
          cur_p[c] = {8'($urandom), $urandom, $urandom};
          if (allow && $urandom_range(3) != 0) cur_v[c] = 1;
        end
        rdy[c] = ($urandom_range(2) != 0);
      end
      apply();
      step();
      cyc++;
      done = 1;
      for (int c = 0; c < 5; c++) if (rcv[c] < N) done = 0;
    end
    cur_v = '0;
    apply();
    for (int c = 0; c < 5; c++) chk({cn[c], "_beats_out"}, 72'(rcv[c]), 72'(N));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
